window_feeder: RTL and testbench
================================

WINDOW_FEEDER -- requirements
Module: window_feeder

Interface
REQ-001 SHALL have parameter IMG_W, default 8, meaning pixels per image row (minimum 2).
REQ-002 SHALL have parameter IMG_H, default 8, meaning rows per image (minimum 2).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port pix_in  input  8  signed pixel; row-major raster order.
REQ-006 SHALL have port pix_valid  input  1  pix_in is offered this cycle.
REQ-007 SHALL have port pix_ready  output  1  pixel is accepted when pix_valid and pix_ready are both high.
REQ-008 SHALL have port win_out  output  72  3x3 window, element 0 (top-left) in bits 71:64 through element 8 (bottom-right) in bits 7:0, row-major; matches the arithmetic_core `in` packing.
REQ-009 SHALL have port win_en  output  1  win_out valid; drives arithmetic_core `en`.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse coincident with the last window of a frame.

Function
REQ-011 SHALL produce exactly IMG_W*IMG_H windows per frame, one per pixel position k = r*IMG_W + c, in increasing k.
REQ-012 SHALL use "same" zero padding: any neighbour outside the image (row <0 or >=IMG_H, column <0 or >=IMG_W) is 8'h00; no wrap across row ends.
REQ-013 SHALL use a state machine with states IDLE, RUN, FLUSH.
REQ-014 IDLE: pix_ready=1; an accepted pixel becomes pixel 0 of a new frame; next state RUN.
REQ-015 RUN: pix_ready=1; pixels are accepted at any rate (gaps allowed); on acceptance of the last pixel (index IMG_W*IMG_H-1), next state FLUSH.
REQ-016 Window k SHALL be registered and presented with win_en=1 in the cycle after pixel index k+IMG_W+1 is accepted.
REQ-017 FLUSH: pix_ready=0; pix_valid is ignored; the remaining IMG_W+1 windows are emitted on consecutive cycles, one per cycle, with no gaps.
REQ-018 frame_done SHALL be high only in the cycle carrying window IMG_W*IMG_H-1; the FSM then returns to IDLE.
REQ-019 A pixel offered in the cycle frame_done is high SHALL be accepted as pixel 0 of the next frame (pix_ready=1 in that cycle).
REQ-020 When no window is due, win_en=0 and win_out SHALL hold its last value.
REQ-021 Pixel storage SHALL be a 2*IMG_W+3 entry shift window advanced on each accepted pixel and on each FLUSH cycle (FLUSH shifts in 8'h00).
REQ-022 Row and column counters of the window centre SHALL drive the padding masks; no arithmetic is performed on pixel values.

Reset
REQ-023 Reset SHALL force, asynchronously: state IDLE, all counters 0, storage 0, win_out 0, win_en 0, frame_done 0, pix_ready 1 (after release).
REQ-024 Reset mid-frame SHALL discard the partial frame; the first pixel accepted after release is pixel 0 of a new frame.

Structure
REQ-025 DATA_W=8, WIN_N=9 and the state encoding SHALL live in the shared package npu_pkg.
REQ-026 The shift window SHALL be a sub-module feeder_shift_line (parameter DEPTH=2*IMG_W+3, shift enable, serial in, parallel out); FSM, counters and padding stay in window_feeder.

Verification
REQ-027 8x8, pixels 1..64 on consecutive cycles -> first win_en in the cycle after pixel value 10 is accepted, window 0 = {0,0,0,0,1,2,0,9,10}; 64 win_en cycles total; frame_done with the 64th.
REQ-028 Same frame with pix_valid high every third cycle -> identical 64 windows in order; FLUSH still emits 9 windows back-to-back.
REQ-029 Edge check -> window 7 = {0,0,0,7,8,0,15,16,0}; window 63 = {55,56,0,63,64,0,0,0,0}; window 8 = {0,1,2,0,9,10,0,17,18}.
REQ-030 pix_valid held high through FLUSH -> pix_ready=0 for 9 cycles, those pixels dropped; pixel offered in the frame_done cycle accepted as the next frame's pixel 0.
REQ-031 Reset asserted after 20 pixels -> win_en and frame_done drop to 0 immediately; a following full frame yields correct window 0 and 64 windows.
REQ-032 Chained to arithmetic_core (bias 0, bound_level 0, step 0, relu and maxpool off) -> core output stream matches the golden convolution file for the same image.

Source files
------------

// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared widths and window feeder state encoding
package npu_pkg;
  localparam int DATA_W = 8;
  localparam int WIN_N  = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } feeder_state_e;
endpackage

// File: rtl/feeder_shift_line.sv
// rtl/feeder_shift_line.sv - serial-in parallel-out pixel shift window
module feeder_shift_line
  import npu_pkg::*;
#(
  parameter int DEPTH = 19
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           shift_en,
  input  logic [DATA_W-1:0]              din,
  output logic [DEPTH-1:0][DATA_W-1:0]   par_out
);
  // Entry 0 holds the most recently shifted pixel.
  logic [DEPTH-1:0][DATA_W-1:0] line_q, line_d;

  always_comb begin
    line_d = line_q;
    if (shift_en) begin
      line_d = {line_q[DEPTH-2:0], din};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign par_out = line_q;
endmodule

// File: rtl/window_feeder.sv
// rtl/window_feeder.sv - raster pixel stream to zero-padded 3x3 window stream
module window_feeder
  import npu_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         pix_in,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  output logic [WIN_N*DATA_W-1:0]   win_out,
  output logic                      win_en,
  output logic                      frame_done
);
  localparam int DEPTH = 2*IMG_W + 3;
  localparam int NPIX  = IMG_W*IMG_H;
  localparam int CNT_W = $clog2(NPIX);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);

  feeder_state_e                   state_q, state_d;
  logic [CNT_W-1:0]                in_cnt_q, in_cnt_d;
  logic [ROW_W-1:0]                row_q, row_d;
  logic [COL_W-1:0]                col_q, col_d;
  logic [WIN_N-1:0][DATA_W-1:0]    win_q, win_d;
  logic                            win_en_q, win_en_d;
  logic                            frame_done_q, frame_done_d;

  logic                            shift_en;
  logic [DATA_W-1:0]               shift_in;
  logic [DEPTH-1:0][DATA_W-1:0]    line;
  logic [DEPTH-1:0][DATA_W-1:0]    view;
  logic [WIN_N-1:0][DATA_W-1:0]    win_calc;
  logic [2:0]                      row_ok, col_ok;
  logic                            accept, emit, last_centre;
  logic                            unused_tail;

  feeder_shift_line #(.DEPTH(DEPTH)) u_line (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .din      (shift_in),
    .par_out  (line)
  );

  assign shift_in    = (state_q == FLUSH) ? '0 : pix_in;
  assign unused_tail = ^line[DEPTH-1];
  assign row_ok      = {row_q != ROW_W'(IMG_H-1), 1'b1, row_q != '0};
  assign col_ok      = {col_q != COL_W'(IMG_W-1), 1'b1, col_q != '0};
  assign last_centre = (row_q == ROW_W'(IMG_H-1)) && (col_q == COL_W'(IMG_W-1));

  // The incoming pixel is the window's bottom-right neighbour, so the window
  // is assembled from the shifter contents plus the value being shifted in.
  always_comb begin
    view[0] = shift_in;
    for (int i = 1; i < DEPTH; i++) begin
      view[i] = line[i-1];
    end
    win_calc = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (row_ok[dr+1] && col_ok[dc+1]) begin
          win_calc[WIN_N-1-((dr+1)*3+(dc+1))] = view[IMG_W+1-dr*IMG_W-dc];
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    in_cnt_d     = in_cnt_q;
    row_d        = row_q;
    col_d        = col_q;
    win_d        = win_q;
    win_en_d     = 1'b0;
    frame_done_d = 1'b0;
    shift_en     = 1'b0;
    emit         = 1'b0;
    pix_ready    = (state_q != FLUSH);
    accept       = pix_valid && pix_ready;

    case (state_q)
      IDLE: begin
        if (accept) begin
          shift_en = 1'b1;
          in_cnt_d = CNT_W'(1);
          state_d  = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          shift_en = 1'b1;
          emit     = (in_cnt_q >= CNT_W'(IMG_W+1));
          if (in_cnt_q == CNT_W'(NPIX-1)) begin
            in_cnt_d = '0;
            state_d  = FLUSH;
          end else begin
            in_cnt_d = in_cnt_q + CNT_W'(1);
          end
        end
      end
      FLUSH: begin
        shift_en = 1'b1;
        emit     = 1'b1;
        if (last_centre) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (emit) begin
      win_en_d = 1'b1;
      win_d    = win_calc;
      if (col_q == COL_W'(IMG_W-1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(IMG_H-1)) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      in_cnt_q     <= '0;
      row_q        <= '0;
      col_q        <= '0;
      win_q        <= '0;
      win_en_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_cnt_q     <= in_cnt_d;
      row_q        <= row_d;
      col_q        <= col_d;
      win_q        <= win_d;
      win_en_q     <= win_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign win_out    = win_q;
  assign win_en     = win_en_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_window_feeder.sv
// tb/tb_window_feeder.sv - self-checking bench for window_feeder
module tb_window_feeder;
  localparam int W = 8;
  localparam int H = 8;
  localparam int N = W*H;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pix_in;
  logic        pix_valid;
  logic        pix_ready;
  logic [71:0] win_out;
  logic        win_en;
  logic        frame_done;

  window_feeder #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .win_out    (win_out),
    .win_en     (win_en),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  img [N];
  logic [7:0]  nxt [N];
  logic [71:0] got[$];
  int          got_t[$];
  int          tcount = 0;
  int          acc_cnt, fd_cnt, fd_idx, first_at, ready_low;
  logic        fd_ready;
  bit          accepted;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference window: plain 2-D indexing of the image with zero padding.
  function automatic logic [71:0] model_win(input int k);
    int r, c, rr, cc;
    logic [71:0] w;
    r = k / W;
    c = k % W;
    w = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr;
        cc = c + dc;
        if (rr >= 0 && rr < H && cc >= 0 && cc < W)
          w[(8 - ((dr+1)*3 + (dc+1)))*8 +: 8] = img[rr*W + cc];
      end
    end
    return w;
  endfunction

  task automatic tick();
    accepted = pix_valid && pix_ready;
    @(posedge clk);
    #1;
    tcount++;
    if (accepted) acc_cnt++;
    if (win_en) begin
      got.push_back(win_out);
      got_t.push_back(tcount);
      if (first_at < 0) first_at = acc_cnt;
    end
    if (frame_done) begin
      fd_cnt++;
      fd_idx   = got.size();
      fd_ready = pix_ready;
    end
  endtask

  task automatic run_frame(input int gap, input bit hold);
    int budget;
    got.delete();
    got_t.delete();
    acc_cnt = 0; fd_cnt = 0; fd_idx = -1; first_at = -1; ready_low = 0;
    fd_ready = 1'b0;
    budget = 0;
    while (acc_cnt < N && budget < 2000) begin
      pix_valid = ((budget % gap) == 0);
      pix_in    = img[acc_cnt];
      tick();
      budget++;
    end
    pix_valid = hold;
    pix_in    = hold ? nxt[0] : 8'h00;
    while (fd_cnt == 0 && budget < 2000) begin
      if (!pix_ready) ready_low++;
      tick();
      budget++;
    end
    check("frame_done_seen", 72'(fd_cnt), 72'd1);
  endtask

  task automatic check_frame(input string name);
    check({name, "_count"}, 72'(got.size()), 72'(N));
    check({name, "_first_latency"}, 72'(first_at), 72'(W+2));
    check({name, "_done_with_last"}, 72'(fd_idx), 72'(N));
    check({name, "_ready_in_done"}, 72'(fd_ready), 72'd1);
    check({name, "_flush_ready_low"}, 72'(ready_low), 72'(W+1));
    check({name, "_accepted"}, 72'(acc_cnt), 72'(N));
    for (int k = 0; k < got.size() && k < N; k++)
      check($sformatf("%s_win%0d", name, k), got[k], model_win(k));
    if (got.size() == N)
      check({name, "_flush_back_to_back"}, 72'(got_t[N-1] - got_t[N-1-W]), 72'(W));
  endtask

  initial begin
    logic [71:0] last_w;
    int          g;
    reset     = 1'b1;
    pix_valid = 1'b0;
    pix_in    = 8'h00;
    #12;
    check("rst_win_en", 72'(win_en), 72'd0);
    check("rst_frame_done", 72'(frame_done), 72'd0);
    check("rst_pix_ready", 72'(pix_ready), 72'd1);
    check("rst_win_out", win_out, 72'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < N; i++) img[i] = 8'(i + 1);
    run_frame(1, 1'b0);
    check_frame("seq");
    if (got.size() == N) begin
      check("seq_w0", got[0], {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd0, 8'd9, 8'd10});
      check("seq_w7", got[7], {8'd0, 8'd0, 8'd0, 8'd7, 8'd8, 8'd0, 8'd15, 8'd16, 8'd0});
      check("seq_w8", got[8], {8'd0, 8'd1, 8'd2, 8'd0, 8'd9, 8'd10, 8'd0, 8'd17, 8'd18});
      check("seq_w63", got[63], {8'd55, 8'd56, 8'd0, 8'd63, 8'd64, 8'd0, 8'd0, 8'd0, 8'd0});
      last_w = got[N-1];
      for (int i = 0; i < 3; i++) begin
        tick();
        check("idle_win_en", 72'(win_en), 72'd0);
        check("idle_hold", win_out, last_w);
      end
    end

    run_frame(3, 1'b0);
    check_frame("gap3");

    for (int i = 0; i < N; i++) img[i] = 8'($urandom);
    for (int i = 0; i < N; i++) nxt[i] = 8'($urandom);
    run_frame(1, 1'b1);
    check_frame("hold");
    for (int i = 0; i < N; i++) img[i] = nxt[i];
    run_frame(1, 1'b0);
    check_frame("chain");

    for (int i = 0; i < N; i++) img[i] = 8'($urandom);
    g = int'($urandom_range(2, 4));
    run_frame(g, 1'b0);
    check_frame("rgap");

    for (int i = 0; i < N; i++) img[i] = 8'($urandom);
    acc_cnt = 0;
    pix_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      pix_in = img[acc_cnt];
      tick();
    end
    check("pre_rst_win_en", 72'(win_en), 72'd1);
    #1 reset = 1'b1;
    pix_valid = 1'b0;
    #1;
    check("mid_rst_win_en", 72'(win_en), 72'd0);
    check("mid_rst_frame_done", 72'(frame_done), 72'd0);
    check("mid_rst_win_out", win_out, 72'd0);
    @(negedge clk);
    reset = 1'b0;
    check("post_rst_pix_ready", 72'(pix_ready), 72'd1);
    for (int i = 0; i < N; i++) img[i] = 8'($urandom);
    run_frame(1, 1'b0);
    check_frame("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
